// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_mmio_responder_pkg: MMIO page offsets, default base and timer control bit positions
package dmem_mmio_responder_pkg;
    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_F000;
    localparam logic [11:0] MMIO_LED    = 12'h000;
    localparam logic [11:0] MMIO_SW     = 12'h004;
    localparam logic [11:0] MMIO_CYC_LO = 12'h008;
    localparam logic [11:0] MMIO_CYC_HI = 12'h00C;
    localparam logic [11:0] MMIO_TCMP   = 12'h010;
    localparam logic [11:0] MMIO_TCTRL  = 12'h014;
    localparam logic [11:0] MMIO_HALT   = 12'h018;
    localparam int TCTRL_EN   = 0;
    localparam int TCTRL_PEND = 1;
endpackage

// File: rtl/dmem_mmio_responder_mmio_timer.sv
// mmio_timer: 64-bit free-running cycle counter with high-word snapshot and compare interrupt
module mmio_timer
    import dmem_mmio_responder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        freeze,
    input  logic        snap,
    input  logic        cmp_we,
    input  logic        ctrl_we,
    input  logic [31:0] wdata,
    output logic [31:0] cycle_lo,
    output logic [31:0] hi_snap,
    output logic [31:0] cmp,
    output logic        en,
    output logic        pend,
    output logic        irq
);
    logic [63:0] cycle;

    // counter, snapshot, compare/control registers; a match set beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle   <= '0;
            hi_snap <= '0;
            cmp     <= '0;
            en      <= 1'b0;
            pend    <= 1'b0;
        end else begin
            if (!freeze) cycle <= cycle + 64'd1;
            if (snap) hi_snap <= cycle[63:32];
            if (cmp_we) cmp <= wdata;
            if (ctrl_we) en <= wdata[TCTRL_EN];
            if (en && cycle[31:0] == cmp) pend <= 1'b1;
            else if (ctrl_we && wdata[TCTRL_PEND]) pend <= 1'b0;
        end
    end

    assign cycle_lo = cycle[31:0];
    assign irq      = pend & en;
endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: CPU data-memory responder decoding word RAM and an MMIO register page
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int          RAM_DEPTH = 1024,
    parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEFAULT,
    parameter int          LED_WIDTH = 16,
    parameter int          SW_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [31:0]          dmem_addr,
    input  logic [31:0]          dmem_wdata,
    input  logic                 dmem_we,
    input  logic                 dmem_re,
    output logic [31:0]          dmem_rdata,
    input  logic [SW_WIDTH-1:0]  sw_in,
    output logic [LED_WIDTH-1:0] led_out,
    output logic                 timer_irq,
    output logic                 halt,
    output logic [31:0]          halt_code
);
    localparam int AW = $clog2(RAM_DEPTH);

    logic [31:0]         ram [RAM_DEPTH];
    logic                ram_hit, mmio_hit, mmio_wr;
    logic [11:0]         off;
    logic [AW-1:0]       idx;
    logic [SW_WIDTH-1:0] sw_s1, sw_s2;
    logic [31:0]         cycle_lo, hi_snap, cmp;
    logic                en, pend;
    logic                unused_addr_bits;

    assign ram_hit          = dmem_addr[31:AW+2] == '0;
    assign mmio_hit         = dmem_addr[31:12] == MMIO_BASE[31:12];
    assign off              = {dmem_addr[11:2], 2'b00};
    assign idx              = dmem_addr[AW+1:2];
    assign mmio_wr          = rst_n && dmem_we && mmio_hit;
    assign unused_addr_bits = ^dmem_addr[1:0];

    mmio_timer u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .freeze  (halt),
        .snap    (dmem_re && mmio_hit && off == MMIO_CYC_LO),
        .cmp_we  (mmio_wr && off == MMIO_TCMP),
        .ctrl_we (mmio_wr && off == MMIO_TCTRL),
        .wdata   (dmem_wdata),
        .cycle_lo(cycle_lo),
        .hi_snap (hi_snap),
        .cmp     (cmp),
        .en      (en),
        .pend    (pend),
        .irq     (timer_irq)
    );

    // word RAM; contents survive reset but writes are dropped while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && dmem_we && ram_hit) ram[idx] <= dmem_wdata;
    end

    // LED, switch synchronizer and first-write-wins halt registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_out   <= '0;
            sw_s1     <= '0;
            sw_s2     <= '0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            sw_s1 <= sw_in;
            sw_s2 <= sw_s1;
            if (mmio_wr && off == MMIO_LED) led_out <= dmem_wdata[LED_WIDTH-1:0];
            if (mmio_wr && off == MMIO_HALT && !halt) begin
                halt      <= 1'b1;
                halt_code <= dmem_wdata;
            end
        end
    end

    // zero-latency read mux over RAM and MMIO registers
    always_comb begin
        dmem_rdata = ram_hit                ? ram[idx] :
                     !mmio_hit              ? 32'd0 :
                     off == MMIO_LED        ? 32'(led_out) :
                     off == MMIO_SW         ? 32'(sw_s2) :
                     off == MMIO_CYC_LO     ? cycle_lo :
                     off == MMIO_CYC_HI     ? hi_snap :
                     off == MMIO_TCMP       ? cmp :
                     off == MMIO_TCTRL      ? {30'd0, pend, en} :
                     off == MMIO_HALT       ? halt_code : 32'd0;
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed self-checking bench for the data-memory/MMIO responder
module tb_dmem_mmio_responder;
    localparam logic [31:0] B = 32'hFFFF_F000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_we = 1'b0;
    logic        dmem_re = 1'b0;
    logic [31:0] dmem_rdata;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;
    logic        timer_irq;
    logic        halt;
    logic [31:0] halt_code;

    int assertions = 0;
    int failures = 0;

    dmem_mmio_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_we   (dmem_we),
        .dmem_re   (dmem_re),
        .dmem_rdata(dmem_rdata),
        .sw_in     (sw_in),
        .led_out   (led_out),
        .timer_irq (timer_irq),
        .halt      (halt),
        .halt_code (halt_code)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        assertions++; if (led_out !== 16'h0) begin failures++; $display("FAIL reset_led: got %h expected %h", led_out, 16'h0); end
        assertions++; if (halt !== 1'b0) begin failures++; $display("FAIL reset_halt: got %b expected 0", halt); end
        assertions++; if (halt_code !== 32'h0) begin failures++; $display("FAIL reset_halt_code: got %h expected 0", halt_code); end
        assertions++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", timer_irq); end
        dmem_addr = B + 32'h14; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_tctrl: got %h expected 0", dmem_rdata); end
        dmem_addr = B + 32'h10; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_tcmp: got %h expected 0", dmem_rdata); end
        dmem_addr = B + 32'h0C; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL reset_cyc_hi: got %h expected 0", dmem_rdata); end
    endtask

    task automatic test_ram;
        @(negedge clk); dmem_addr = 32'h4; dmem_wdata = 32'h0; dmem_we = 1'b1;
        @(negedge clk); dmem_addr = 32'h0; dmem_wdata = 32'd30;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'd30) begin failures++; $display("FAIL ram_rd0: got %h expected %h", dmem_rdata, 32'd30); end
        dmem_addr = 32'h2; #1;
        assertions++; if (dmem_rdata !== 32'd30) begin failures++; $display("FAIL ram_low_bits_ignored: got %h expected %h", dmem_rdata, 32'd30); end
        @(negedge clk); dmem_addr = 32'h4; dmem_wdata = 32'h55; dmem_we = 1'b1; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL ram_same_cycle_old: got %h expected 0", dmem_rdata); end
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'h55) begin failures++; $display("FAIL ram_rd4: got %h expected 55", dmem_rdata); end
        @(negedge clk); dmem_addr = 32'h1000; dmem_wdata = 32'hDEAD; dmem_we = 1'b1;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL ram_oob_read: got %h expected 0", dmem_rdata); end
        dmem_addr = 32'h0; #1;
        assertions++; if (dmem_rdata !== 32'd30) begin failures++; $display("FAIL ram_oob_no_alias: got %h expected %h", dmem_rdata, 32'd30); end
    endtask

    task automatic test_led_sw;
        @(negedge clk); dmem_addr = B; dmem_wdata = 32'hABCD_1234; dmem_we = 1'b1;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (led_out !== 16'h1234) begin failures++; $display("FAIL led_out: got %h expected 1234", led_out); end
        assertions++; if (dmem_rdata !== 32'h0000_1234) begin failures++; $display("FAIL led_read: got %h expected 00001234", dmem_rdata); end
        @(negedge clk); sw_in = 16'h00A5; dmem_addr = B + 32'h4; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL sw_edge0: got %h expected 0", dmem_rdata); end
        @(negedge clk); #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL sw_edge1: got %h expected 0", dmem_rdata); end
        @(negedge clk); #1;
        assertions++; if (dmem_rdata !== 32'hA5) begin failures++; $display("FAIL sw_edge2: got %h expected a5", dmem_rdata); end
    endtask

    task automatic test_timer;
        @(negedge clk); rst_n = 1'b0; dmem_we = 1'b0;
        @(negedge clk); rst_n = 1'b1; dmem_we = 1'b1; dmem_addr = B + 32'h10; dmem_wdata = 32'd100;
        @(negedge clk); dmem_addr = B + 32'h14; dmem_wdata = 32'd1;
        @(negedge clk); dmem_we = 1'b0;
        repeat (98) @(negedge clk);
        #1;
        assertions++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_before_match: got %b expected 0", timer_irq); end
        assertions++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL timer_ctrl_before: got %h expected 1", dmem_rdata); end
        @(negedge clk); #1;
        assertions++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_irq_rise: got %b expected 1", timer_irq); end
        assertions++; if (dmem_rdata !== 32'h3) begin failures++; $display("FAIL timer_ctrl_pend: got %h expected 3", dmem_rdata); end
        @(negedge clk); dmem_we = 1'b1; dmem_addr = B + 32'h10; dmem_wdata = 32'd110;
        @(negedge clk); dmem_we = 1'b0;
        repeat (7) @(negedge clk);
        dmem_we = 1'b1; dmem_addr = B + 32'h14; dmem_wdata = 32'd3;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'h3) begin failures++; $display("FAIL timer_set_beats_w1c: got %h expected 3", dmem_rdata); end
        assertions++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_irq_held: got %b expected 1", timer_irq); end
        @(negedge clk); dmem_we = 1'b1;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL timer_w1c: got %h expected 1", dmem_rdata); end
        assertions++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_irq_cleared: got %b expected 0", timer_irq); end
        @(negedge clk); dmem_we = 1'b1; dmem_addr = B + 32'h10; dmem_wdata = 32'd120;
        @(negedge clk); dmem_we = 1'b0;
        repeat (6) @(negedge clk);
        dmem_we = 1'b1; dmem_addr = B + 32'h14; dmem_wdata = 32'd0; #1;
        assertions++; if (timer_irq !== 1'b1) begin failures++; $display("FAIL timer_irq_third: got %b expected 1", timer_irq); end
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (timer_irq !== 1'b0) begin failures++; $display("FAIL timer_irq_masked: got %b expected 0", timer_irq); end
        assertions++; if (dmem_rdata !== 32'h2) begin failures++; $display("FAIL timer_pend_kept: got %h expected 2", dmem_rdata); end
    endtask

    task automatic test_snapshot;
        @(negedge clk); force dut.u_timer.cycle = 64'h0000_0000_FFFF_FFFE;
        @(negedge clk); release dut.u_timer.cycle;
        @(negedge clk); dmem_addr = B + 32'h8; dmem_re = 1'b1; #1;
        assertions++; if (dmem_rdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL snap_lo: got %h expected ffffffff", dmem_rdata); end
        @(negedge clk); dmem_re = 1'b0;
        repeat (2) @(negedge clk);
        dmem_addr = B + 32'hC; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL snap_hi_held: got %h expected 0", dmem_rdata); end
        dmem_addr = B + 32'h8; #1;
        assertions++; if (dmem_rdata !== 32'h2) begin failures++; $display("FAIL snap_lo_wrapped: got %h expected 2", dmem_rdata); end
        dmem_re = 1'b1;
        @(negedge clk); dmem_re = 1'b0; dmem_addr = B + 32'hC; #1;
        assertions++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL snap_hi_carry: got %h expected 1", dmem_rdata); end
    endtask

    task automatic test_halt;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; dmem_we = 1'b1; dmem_addr = B + 32'h18; dmem_wdata = 32'h600D;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (halt !== 1'b1) begin failures++; $display("FAIL halt_set: got %b expected 1", halt); end
        assertions++; if (halt_code !== 32'h600D) begin failures++; $display("FAIL halt_code: got %h expected 600d", halt_code); end
        assertions++; if (dmem_rdata !== 32'h600D) begin failures++; $display("FAIL halt_read: got %h expected 600d", dmem_rdata); end
        @(negedge clk); dmem_we = 1'b1; dmem_wdata = 32'hBAD;
        @(negedge clk); dmem_we = 1'b0; #1;
        assertions++; if (halt_code !== 32'h600D) begin failures++; $display("FAIL halt_first_wins: got %h expected 600d", halt_code); end
        dmem_addr = B + 32'h8; #1;
        assertions++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL halt_freeze_a: got %h expected 1", dmem_rdata); end
        @(negedge clk); dmem_addr = B; dmem_wdata = 32'h55; dmem_we = 1'b1;
        @(negedge clk); dmem_we = 1'b0;
        @(negedge clk); dmem_addr = B + 32'h8; #1;
        assertions++; if (dmem_rdata !== 32'h1) begin failures++; $display("FAIL halt_freeze_b: got %h expected 1", dmem_rdata); end
        assertions++; if (led_out !== 16'h55) begin failures++; $display("FAIL halt_led_write: got %h expected 55", led_out); end
    endtask

    task automatic test_reset_mid_run;
        @(negedge clk); rst_n = 1'b0; dmem_we = 1'b1; dmem_addr = B; dmem_wdata = 32'hFFFF;
        @(negedge clk); rst_n = 1'b1; dmem_we = 1'b0; #1;
        assertions++; if (led_out !== 16'h0) begin failures++; $display("FAIL rst_led: got %h expected 0", led_out); end
        assertions++; if (halt !== 1'b0) begin failures++; $display("FAIL rst_halt: got %b expected 0", halt); end
        assertions++; if (halt_code !== 32'h0) begin failures++; $display("FAIL rst_halt_code: got %h expected 0", halt_code); end
        dmem_addr = B + 32'h8; #1;
        assertions++; if (dmem_rdata !== 32'h0) begin failures++; $display("FAIL rst_cycle: got %h expected 0", dmem_rdata); end
        @(negedge clk); rst_n = 1'b0; dmem_we = 1'b1; dmem_addr = 32'h0; dmem_wdata = 32'hBEEF;
        @(negedge clk); rst_n = 1'b1; dmem_we = 1'b0; #1;
        assertions++; if (dmem_rdata !== 32'd30) begin failures++; $display("FAIL rst_ram0: got %h expected %h", dmem_rdata, 32'd30); end
        dmem_addr = 32'h4; #1;
        assertions++; if (dmem_rdata !== 32'h55) begin failures++; $display("FAIL rst_ram4: got %h expected 55", dmem_rdata); end
    endtask

    initial begin
        test_reset();
        test_ram();
        test_led_sw();
        test_timer();
        test_snapshot();
        test_halt();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end
endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
Responder for the CPU data-memory port. It terminates the dmem_addr/dmem_wdata/dmem_we/dmem_re bus. It decodes each access into a word-addressed data RAM or a small MMIO register page: LEDs, switches, 64-bit cycle counter, compare timer with interrupt, and a halt/signature register for self-checking programs. It sits beside riscv_cpu_top at the SoC top and replaces bench-side behavioural data memories.

Parameters:
RAM_DEPTH, 1024, data RAM size in 32-bit words (power of two; RAM spans 0 .. 4*RAM_DEPTH-1)
MMIO_BASE, 32'hFFFF_F000, base of the 4 KiB MMIO page
LED_WIDTH, 16, width of LED output register
SW_WIDTH, 16, width of switch input

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
dmem_addr  in  32  byte address from CPU; addr[1:0] ignored (word access only)
dmem_wdata  in  32  write data
dmem_we  in  1  write strobe, committed at rising edge
dmem_re  in  1  read strobe; used for side effects only (snapshot)
dmem_rdata  out  32  read data, combinational from addr and current state
sw_in  in  SW_WIDTH  asynchronous board switches
led_out  out  LED_WIDTH  LED register
timer_irq  out  1  timer interrupt level
halt  out  1  sticky halt flag
halt_code  out  32  value written to HALT

Behaviour:
- Decode: RAM hit when addr < 4*RAM_DEPTH, index addr[log2(RAM_DEPTH)+1:2]. MMIO hit when addr[31:12] == MMIO_BASE[31:12], offset addr[11:0]. All other addresses: read 0, write ignored.
- Read latency 0: dmem_rdata is combinational in the same cycle, independent of dmem_re. A same-cycle write to the same address returns the pre-edge value.
- Write: takes effect at the rising edge when dmem_we=1. The written value is visible to reads the next cycle.
- RAM contents are not cleared by reset.
- MMIO offsets:
  - 0x00 LED: RW; low LED_WIDTH bits stored, upper bits read 0.
  - 0x04 SW: RO; value from a 2-FF synchronizer on sw_in, zero-extended.
  - 0x08 CYCLE_LO: RO; live low word. A read (dmem_re=1) latches cycle[63:32] into hi_snap at the edge.
  - 0x0C CYCLE_HI: RO; returns hi_snap.
  - 0x10 TIMER_CMP: RW, 32-bit.
  - 0x14 TIMER_CTRL: bit0 EN (RW); bit1 PEND (read; write 1 clears); other bits read 0.
  - 0x18 HALT: write sets halt=1 and halt_code=wdata; first write wins, later writes ignored; reads return halt_code.
  - Unused offsets: read 0, write ignored.
- Cycle counter:
  - 64-bit, 0 at reset, +1 every cycle with rst_n=1 and halt=0.
  - Wraps 2^64-1 -> 0; the carry from low to high word occurs in the same cycle.
  - Freezes once halt=1.
- Timer:
  - In any cycle with EN=1 and cycle[31:0]==TIMER_CMP, PEND sets at the edge.
  - A W1C write to PEND in the same cycle as a set event: set wins.
  - timer_irq = PEND & EN, registered-derived, no combinational path from the bus.
- Reset (rst_n=0 at edge): led_out=0, sync FFs=0, cycle=0, hi_snap=0, TIMER_CMP=0, EN=0, PEND=0, halt=0, halt_code=0.
  - While reset is held, dmem_we is ignored for both MMIO and RAM.
  - Reset mid-operation discards any in-flight write that cycle.
- Writes while halt=1 are still accepted except by HALT; only the counter freezes.

Decomposition:
- Add to defines.vh: MMIO offset constants (`MMIO_LED`, `MMIO_SW`, `MMIO_CYC_LO`, `MMIO_CYC_HI`, `MMIO_TCMP`, `MMIO_TCTRL`, `MMIO_HALT`), the default MMIO base, and TIMER_CTRL bit indices.
- One sub-module: mmio_timer. It holds the 64-bit counter, hi_snap, TIMER_CMP, EN/PEND and irq, with inputs for halt freeze, snapshot pulse and register write strobes.
- Top module holds address decode, RAM array, LED/SW/HALT registers and the read mux.

Test Plan:
- RAM write/read:
  - SW 30 @0x0, then read 0x0 -> rdata=30 the next cycle.
  - Read of 0x4 during a write to 0x4 -> old value 0.
  - Write @4*RAM_DEPTH (out of range) -> read 0, RAM[0] unchanged.
- LED/SW:
  - Write 0xABCD1234 to MMIO_BASE+0x00 -> led_out=0x1234, read returns 0x00001234.
  - sw_in=0x00A5 -> SW read returns 0xA5 no earlier than the 2nd edge after the change.
- Cycle snapshot:
  - Preload counter to 0x0000_0000_FFFF_FFFE via force.
  - Read CYCLE_LO at value 0xFFFFFFFF, then read CYCLE_HI 3 cycles later -> 0x0 (snapshot, not live 0x1).
  - Live low word has wrapped to 0x2.
- Timer:
  - CMP=100, EN=1 -> timer_irq rises the cycle after the counter passes 100.
  - W1C in the same cycle as a second match (CMP rewritten to that value) -> PEND stays 1.
  - EN=0 -> timer_irq=0 while PEND=1.
- Halt:
  - Write 0x600D to HALT -> halt=1, halt_code=0x600D, counter frozen.
  - Second write of 0xBAD -> halt_code remains 0x600D.
- Reset mid-run:
  - Assert rst_n=0 for 1 cycle concurrent with dmem_we to LED -> led_out=0, counter=0, halt=0.
  - RAM contents written before reset still read back unchanged.
